// File: rtl/button_stepper.sv
// Push-button front end for the up/down counter: synchronises and debounces two raw
// buttons, then emits one step per press plus auto-repeat steps while a button is held.
module button_stepper #(
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int TMR_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    output logic step,
    output logic up_down,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] DEB_T    = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_T   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_T = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (v == TMR_MAX) ? v : v + TMR_W'(1);
    endfunction

    // Index 1 is the up button, index 0 the down button.
    logic [1:0]       raw;
    logic [1:0]       sync0_q;
    logic [1:0]       sync1_q;
    logic [1:0]       deb_q;
    logic [TMR_W-1:0] deb_cnt_q [2];

    assign raw = {btn_up, btn_dn};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync0_q <= '0;
            sync1_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync0_q <= raw;
            sync1_q <= sync0_q;
            for (int i = 0; i < 2; i++) begin
                if (sync1_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_T) begin
                    deb_q[i]     <= sync1_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= sat_inc(deb_cnt_q[i]);
                end
            end
        end
    end

    // Both buttons down is deliberately not a request.
    logic req;
    logic dir;
    assign req = deb_q[1] ^ deb_q[0];
    assign dir = deb_q[1];

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    step_d  = 1'b1;
                    dir_d   = dir;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (dir != dir_q) begin
                    // A direction flip restarts the press from scratch.
                    step_d  = 1'b1;
                    dir_d   = dir;
                    timer_d = '0;
                    state_d = HOLD;
                end else if (timer_q == ((state_q == HOLD) ? HOLD_T : REPEAT_T)) begin
                    step_d  = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign step    = step_q;
    assign up_down = dir_q;
    assign held    = (state_q != IDLE);

endmodule

// File: doc/button_stepper.md
Name: button_stepper

Overview:
- Input-conditioning stage directly upstream of the 4-bit up/down counter.
- Turns two raw push-buttons (up, down) into a direction level (up_down) and single-cycle step pulses.
- Per button: 2-flop synchroniser and debounce. A shared press FSM issues one step on press, then auto-repeats while the button is held.
- step drives the counter's count-enable; up_down drives its direction input.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronised cycles needed to change a debounced button level (>=1)
HOLD_CYCLES, 16, cycles from first step to first auto-repeat step (>=2)
REPEAT_CYCLES, 8, cycles between auto-repeat steps (>=2)
TMR_W, 8, width of the debounce and hold/repeat timers; must hold max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)

Ports:
clk      input   1  system clock; all state updates on the rising edge
reset    input   1  synchronous, active-low reset (reset==0 at a rising edge clears all state)
btn_up   input   1  raw up button, asynchronous, active-high
btn_dn   input   1  raw down button, asynchronous, active-high
step     output  1  one-cycle pulse requesting one count
up_down  output  1  direction: 1 = up, 0 = down; valid whenever step==1, held otherwise
held     output  1  1 while a valid press is being serviced (FSM not IDLE)

Behaviour:
- Reset (reset==0 at an edge): step=0, up_down=0, held=0. Synchronisers, debounced levels and timers all go to 0; FSM goes to IDLE. Reset overrides everything, including mid-HOLD or mid-REPEAT.
- Synchroniser: two flops per button, giving a 2-edge delay to s_up/s_dn.
- Debounce, per button:
  - A counter increments while the s_x level differs from the debounced level d_x, and clears whenever they are equal.
  - When the counter reaches DEB_CYCLES, d_x takes the s_x level and the counter clears.
  - Any glitch shorter than DEB_CYCLES produces no change in d_x.
- Request:
  - req = d_up XOR d_dn; dir = d_up.
  - Both buttons pressed counts as no request.
- FSM states: IDLE, HOLD, REPEAT. All outputs are registered.
  - IDLE, req=1: step=1, up_down=dir, timer=0, go to HOLD.
  - HOLD, req=0: go to IDLE, no step.
  - HOLD, req=1 and dir differs from up_down: treated as a new press. step=1, up_down=dir, timer=0, stay in HOLD.
  - HOLD, otherwise: timer+1. When the sampled timer == HOLD_CYCLES-1: step=1, timer=0, go to REPEAT.
  - REPEAT, req=0: go to IDLE.
  - REPEAT, direction change: same as HOLD (step in the new direction, timer=0, go to HOLD).
  - REPEAT, otherwise: timer+1. When the sampled timer == REPEAT_CYCLES-1: step=1, timer=0.
- Output rules:
  - step is 0 in every cycle not listed above; it is never high for two consecutive cycles.
  - held=1 exactly in HOLD and REPEAT.
  - up_down changes only in a cycle where step=1.
- Latency:
  - With a raw press stable from edge 0, d_x rises at edge 2+DEB_CYCLES and the first step is high after edge 3+DEB_CYCLES.
  - Release takes the same debounce delay. Repeat steps due before d_x falls are still issued.
- Timers saturate at their terminal value and never wrap.
- Downstream saturation at 0 or 15 is the counter's concern; steps keep being issued.

Test Plan:
Defaults used throughout (DEB=4, HOLD=16, REPEAT=8), with the raw input changing just after edge 0.
1. Reset: reset=0 for 3 edges with both buttons held -> step=0, up_down=0, held=0 throughout, and no step on the first edge after reset=1 until the debounce delay has elapsed.
2. Single tap: btn_up high for 12 cycles -> exactly one step, at edge 7, with up_down=1; held=1 from edge 7 until d_up falls.
3. Hold and repeat: btn_dn held for 60 cycles -> steps at edges 7, 23, 31, 39, 47, 55, 63 with up_down=0; held drops after edge 67 (the debounced release at edge 66 seen by the FSM).
4. Glitch rejection: btn_up pulses of 1, 2 and 3 cycles, separated by 10 low cycles -> no step, held stays 0.
5. Both buttons: btn_up and btn_dn asserted together for 40 cycles -> no step. Then btn_dn released while btn_up stays high -> one step with up_down=1, 7 edges after the release (the d_dn debounce delay).
6. Direction change and reset mid-operation:
   - btn_up held into REPEAT, then switched to btn_dn -> d_dn rises at edge N+6 and d_up falls at the same edge. A step with up_down=0 follows at edge N+7 (the FSM's registered response) and restarts HOLD; no step is issued while both debounced levels are high.
   - reset=0 asserted for one edge during REPEAT -> outputs cleared at that edge and no further step until a fresh debounced press.
